// File: rtl/uart_rx_param.sv
// Parametrised async serial receiver: mid-bit sampling, false-start rejection,
// framing/parity/break flags, one-word valid/ready holding register with overrun.
module uart_rx_param #(
  parameter int BAUD_DIV  = 104,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 brk,
  output logic                 overrun
);

  localparam logic [15:0] HALF_CNT  = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL_CNT  = 16'(BAUD_DIV - 1);
  localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DELIVER, S_WAIT_HIGH
  } state_t;

  state_t                 state, state_nx;
  logic                   rx_m, rx_s;
  logic [15:0]            baud_cnt;
  logic [3:0]             bitc;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_acc;   // running XOR of data bits
  logic                   fe_acc;    // any stop bit sampled 0
  logic                   pe_acc;    // parity check result
  logic                   any_one;   // a 1 was seen in data, parity or first stop
  logic                   tick;

  assign tick = (baud_cnt == 16'd0);

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; every transition out of a sampling state waits for tick.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (!rx_s) state_nx = S_START;
      S_START:     if (tick) state_nx = rx_s ? S_IDLE : S_DATA;
      S_DATA:      if (tick && bitc == LAST_DATA)
                     state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY:    if (tick) state_nx = S_STOP;
      S_STOP:      if (tick && bitc == LAST_STOP) state_nx = S_DELIVER;
      S_DELIVER:   state_nx = (fe_acc && !rx_s) ? S_WAIT_HIGH : S_IDLE;
      S_WAIT_HIGH: if (rx_s) state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  // Bit timing, shift register and per-frame flag accumulation.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      baud_cnt <= '0;
      bitc     <= '0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      fe_acc   <= 1'b0;
      pe_acc   <= 1'b0;
      any_one  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          par_acc <= 1'b0;
          fe_acc  <= 1'b0;
          pe_acc  <= 1'b0;
          any_one <= 1'b0;
          if (!rx_s) baud_cnt <= HALF_CNT;
        end
        S_START: begin
          if (tick) begin
            baud_cnt <= FULL_CNT;
            bitc     <= '0;
          end else baud_cnt <= baud_cnt - 16'd1;
        end
        S_DATA: begin
          if (tick) begin
            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
            par_acc  <= par_acc ^ rx_s;
            any_one  <= any_one | rx_s;
            baud_cnt <= FULL_CNT;
            bitc     <= (bitc == LAST_DATA) ? 4'd0 : bitc + 4'd1;
          end else baud_cnt <= baud_cnt - 16'd1;
        end
        S_PARITY: begin
          if (tick) begin
            pe_acc   <= (PARITY == 1) ? (par_acc ^ rx_s) : ~(par_acc ^ rx_s);
            any_one  <= any_one | rx_s;
            baud_cnt <= FULL_CNT;
          end else baud_cnt <= baud_cnt - 16'd1;
        end
        S_STOP: begin
          if (tick) begin
            if (!rx_s)        fe_acc  <= 1'b1;
            if (bitc == 4'd0) any_one <= any_one | rx_s;
            bitc     <= bitc + 4'd1;
            baud_cnt <= FULL_CNT;
          end else baud_cnt <= baud_cnt - 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Holding register: load on delivery if empty or being drained, else flag overrun.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      brk        <= 1'b0;
      overrun    <= 1'b0;
    end else if (state == S_DELIVER) begin
      if (!valid || ready) begin
        data       <= shreg;
        frame_err  <= fe_acc;
        parity_err <= (PARITY != 0) && pe_acc;
        brk        <= ~any_one;
        valid      <= 1'b1;
        overrun    <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (valid && ready) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1, 7E1, 8N2) at BAUD_DIV=16,
// scoreboarded against words pushed when each frame is sent.
module tb_uart_rx_param;

  localparam int BD = 16;

  logic       clk = 1'b0;
  logic [2:0] rstn = 3'b000;
  logic [2:0] rx   = 3'b111;
  logic [2:0] rdy  = 3'b111;
  logic [2:0] v, fe, pe, bk, ov;
  logic [7:0] d0, d2;
  logic [6:0] d1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int nrx [3] = '{0, 0, 0};
  logic [13:0] sbq [$];   // {inst[1:0], data[8:0], fe, pe, brk}

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rstn(rstn[0]), .rx(rx[0]), .data(d0), .valid(v[0]), .ready(rdy[0]),
    .frame_err(fe[0]), .parity_err(pe[0]), .brk(bk[0]), .overrun(ov[0]));
  uart_rx_param #(.BAUD_DIV(BD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rstn(rstn[1]), .rx(rx[1]), .data(d1), .valid(v[1]), .ready(rdy[1]),
    .frame_err(fe[1]), .parity_err(pe[1]), .brk(bk[1]), .overrun(ov[1]));
  uart_rx_param #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
    .clk(clk), .rstn(rstn[2]), .rx(rx[2]), .data(d2), .valid(v[2]), .ready(rdy[2]),
    .frame_err(fe[2]), .parity_err(pe[2]), .brk(bk[2]), .overrun(ov[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_t();
    repeat (BD) tick();
  endtask

  task automatic expect_w(input int i, input logic [8:0] d, input logic f, input logic p,
                          input logic b);
    logic [1:0] id;
    id = i[1:0];
    sbq.push_back({id, d, f, p, b});
  endtask

  // pb < 0 means no parity bit; st holds stop-bit levels, bit 0 first.
  task automatic send(input int i, input logic [8:0] d, input int nb, input int pb,
                      input logic [1:0] st, input int ns);
    rx[i] = 1'b0;
    bit_t();
    for (int k = 0; k < nb; k++) begin
      rx[i] = d[k];
      bit_t();
    end
    if (pb >= 0) begin
      rx[i] = pb[0];
      bit_t();
    end
    for (int k = 0; k < ns; k++) begin
      rx[i] = st[k];
      bit_t();
    end
    rx[i] = 1'b1;
  endtask

  // Scoreboard: every accepted word is compared against the oldest expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (v[i] && rdy[i] && rstn[i]) begin
        logic [13:0] obs, exp;
        logic [8:0]  dd;
        logic [1:0]  id;
        id = i[1:0];
        dd = (i == 0) ? {1'b0, d0} : (i == 1) ? {2'b00, d1} : {1'b0, d2};
        obs = {id, dd, fe[i], pe[i], bk[i]};
        exp = (sbq.size() != 0) ? sbq.pop_front() : 14'h3fff;
        nrx[i]++;
        chk("sb_word", 32'(obs), 32'(exp));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int t0, lat, base;
    repeat (4) tick();
    chk("rst_valid", 32'(v), 32'd0);
    chk("rst_flags", 32'({fe, pe, bk, ov}), 32'd0);
    chk("rst_data", 32'({d0, d1, d2}), 32'd0);
    rstn = 3'b111;
    repeat (5) tick();

    // 8N1 0xA5: latency and single-cycle valid pulse
    expect_w(0, 9'h0A5, 1'b0, 1'b0, 1'b0);
    t0  = cyc;
    lat = -1;
    fork
      send(0, 9'h0A5, 8, -1, 2'b11, 1);
      begin
        for (int k = 0; k < 300; k++) begin
          @(negedge clk);
          if (v[0]) begin
            lat = cyc - t0;
            break;
          end
        end
        chk("lat_a5", 32'(lat >= 154 && lat <= 156), 32'd1);
        @(negedge clk);
        chk("pulse_a5", 32'(v[0]), 32'd0);
      end
    join
    repeat (10) tick();

    // 7E1 0x41: correct parity bit 0, then wrong parity bit 1
    expect_w(1, 9'h041, 1'b0, 1'b0, 1'b0);
    send(1, 9'h041, 7, 0, 2'b11, 1);
    repeat (10) tick();
    expect_w(1, 9'h041, 1'b0, 1'b1, 1'b0);
    send(1, 9'h041, 7, 1, 2'b11, 1);
    repeat (10) tick();

    // Glitch: 5 cycles low is rejected, next frame is clean
    base = nrx[0];
    rx[0] = 1'b0;
    repeat (5) tick();
    rx[0] = 1'b1;
    repeat (40) tick();
    chk("glitch_none", 32'(nrx[0] - base), 32'd0);
    chk("glitch_valid", 32'(v[0]), 32'd0);
    expect_w(0, 9'h03C, 1'b0, 1'b0, 1'b0);
    send(0, 9'h03C, 8, -1, 2'b11, 1);
    repeat (10) tick();

    // Overrun: hold ready low across two frames
    rdy[0] = 1'b0;
    send(0, 9'h011, 8, -1, 2'b11, 1);
    send(0, 9'h022, 8, -1, 2'b11, 1);
    repeat (10) tick();
    chk("ovr_data", 32'(d0), 32'h11);
    chk("ovr_valid", 32'(v[0]), 32'd1);
    chk("ovr_flag", 32'(ov[0]), 32'd1);
    expect_w(0, 9'h011, 1'b0, 1'b0, 1'b0);
    rdy[0] = 1'b1;
    tick();
    rdy[0] = 1'b0;
    chk("ovr_clr_valid", 32'(v[0]), 32'd0);
    chk("ovr_clr_flag", 32'(ov[0]), 32'd0);
    rdy[0] = 1'b1;
    repeat (5) tick();

    // Break: 30 bit times low gives exactly one word
    base = nrx[0];
    expect_w(0, 9'h000, 1'b1, 1'b0, 1'b1);
    rx[0] = 1'b0;
    repeat (30 * BD) tick();
    rx[0] = 1'b1;
    repeat (40) tick();
    chk("brk_count", 32'(nrx[0] - base), 32'd1);
    expect_w(0, 9'h05A, 1'b0, 1'b0, 1'b0);
    send(0, 9'h05A, 8, -1, 2'b11, 1);
    repeat (10) tick();

    // 8N2: second stop bit low is a framing error, not a break
    expect_w(2, 9'h099, 1'b1, 1'b0, 1'b0);
    send(2, 9'h099, 8, -1, 2'b01, 2);
    repeat (20) tick();

    // Hold a word, then reset mid data bit; all outputs clear
    rdy[2] = 1'b0;
    send(2, 9'h033, 8, -1, 2'b11, 2);
    repeat (10) tick();
    chk("hold_data", 32'(d2), 32'h33);
    chk("hold_valid", 32'(v[2]), 32'd1);
    fork
      send(2, 9'h0FF, 8, -1, 2'b11, 2);
      begin
        repeat (3 * BD) tick();
        rstn[2] = 1'b0;
        tick();
        chk("mrst_out", 32'({d2, v[2], fe[2], pe[2], bk[2], ov[2]}), 32'd0);
        rstn[2] = 1'b1;
      end
    join
    repeat (10) tick();
    chk("mrst_idle", 32'(v[2]), 32'd0);
    rdy[2] = 1'b1;
    expect_w(2, 9'h04B, 1'b0, 1'b0, 1'b0);
    send(2, 9'h04B, 8, -1, 2'b11, 2);
    repeat (20) tick();

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
